vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator: derives a pixel-rate enable from clk, runs horizontal and vertical
//  counters over a programmable video mode, and produces pixel coordinates, active-video flag, sync signals
//  of selectable polarity, line/frame start strobes and a frame counter. Sits between the system clock and
//  the pixel/framebuffer pipeline; PIPE delays all timing outputs to align with downstream pixel latency.
// PARAMETERS
//  CLK_DIV   2    clk cycles per pixel (>=1); pix_ce high 1 clk in every CLK_DIV
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (pixels)
//  H_SYNC    96   horizontal sync width (pixels)
//  H_BP      48   horizontal back porch (pixels)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vertical sync width (lines)
//  V_BP      33   vertical back porch (lines)
//  HS_POL    0    hsync asserted level (0 = active-low)
//  VS_POL    0    vsync asserted level
//  CW        10   width of x/y; must satisfy 2^CW >= H_TOTAL and >= V_TOTAL
//  FCW       8    frame_count width
//  PIPE      0    extra clk-cycle delay stages on all outputs except pix_ce (0..8)
// PORTS
//  clk          in   1    system clock
//  rst          in   1    synchronous, active-high reset
//  en           in   1    run enable; low freezes divider and counters
//  pix_ce       out  1    pixel clock enable, undelayed
//  x            out  CW   horizontal position 0..H_TOTAL-1
//  y            out  CW   vertical position 0..V_TOTAL-1
//  active       out  1    x<H_ACTIVE && y<V_ACTIVE
//  hsync        out  1    horizontal sync, polarity HS_POL
//  vsync        out  1    vertical sync, polarity VS_POL
//  line_start   out  1    1-clk strobe: first clk outputs show x==0
//  frame_start  out  1    1-clk strobe: first clk outputs show x==0,y==0
//  frame_count  out  FCW  frames started since reset, wraps
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Internal hc, vc, div counters.
//  - Reset: div=0, hc=vc=0, frame_count=0; all outputs incl. pipeline stages: pix_ce=0, x=y=0, active=0,
//    hsync=~HS_POL, vsync=~VS_POL, line_start=frame_start=0.
//  - div counts 0..CLK_DIV-1 while en; pix_ce=1 when div==CLK_DIV-1 && en (CLK_DIV=1: pix_ce=en).
//  - On pix_ce: hc<H_TOTAL-1 -> hc+1; else hc=0 and vc advances (wrap at V_TOTAL-1 to 0, frame_count+1 mod 2^FCW).
//  - Outputs are registered decodes of (hc,vc): latency 1 clk + PIPE clks from counter state.
//  - hsync asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; vsync iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC
//    (vsync decoded from y only, changes with the line).
//  - Each (x,y) is held CLK_DIV clks; line_start/frame_start high only on the first of them.
//  - First clk after rst release with en=1: x=y=0, active=1, line_start=frame_start=1, frame_count=0.
//  - frame_count updates in the same clk as the frame_start it counts (first frame after reset = 0).
//  - en low: div, hc, vc frozen; outputs hold last values; strobes low; resume continues mid-pixel, no re-strobe.
//  - rst mid-frame overrides everything in the next clk; PIPE stages flushed to reset values.
//  - All PIPE stages shift every clk (not gated by en) so the delay is exact in clk cycles.
// TESTING
//  1 Defaults, en=1 after reset: x advances every 2 clk; line_start period 1600 clk; frame_start period 840000 clk.
//  2 Defaults: hsync low exactly for x=656..751, vsync low exactly for y=490..491; active low for x>=640 or y>=480.
//  3 Wrap: x=799,y=524 -> next pixel x=0,y=0, frame_start=1 one clk, frame_count 255->0 with FCW=8.
//  4 CLK_DIV=1, H_ACTIVE=8,H_FP=2,H_SYNC=2,H_BP=2,V 4/1/1/1, HS_POL=VS_POL=1: x period 14 clk, hsync high x=10..11.
//  5 en low for 37 clk at x=100: x held, no strobes; resumes at x=101 after remaining div count.
//  6 PIPE=3: every output equals PIPE=0 run delayed exactly 3 clk; rst mid-line -> next clk all reset values.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: run enable toward the generator, pixel strobe, coordinates and sync/strobe outputs back.
interface vga_timing_gen_if #(
  parameter int CW  = 10,
  parameter int FCW = 8
);
  logic           en;
  logic           pix_ce;
  logic [CW-1:0]  x;
  logic [CW-1:0]  y;
  logic           active;
  logic           hsync;
  logic           vsync;
  logic           line_start;
  logic           frame_start;
  logic [FCW-1:0] frame_count;

  modport master (
    input  en,
    output pix_ce, x, y, active, hsync, vsync, line_start, frame_start, frame_count
  );

  modport slave (
    output en,
    input  pix_ce, x, y, active, hsync, vsync, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel enable from clk, h/v counters, registered decode + PIPE delay stages.
// Outputs lag counter state by 1+PIPE clk; en low freezes counters, holds outputs and drops strobes.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10,
  parameter int FCW      = 8,
  parameter int PIPE     = 0
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master tim
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  // One extra bit so a sync end equal to 2^CW still compares correctly.
  localparam logic [CW:0] H_ACT_E = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SS_E  = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SE_E  = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_E = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SS_E  = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SE_E  = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;
    logic           active;
    logic           hsync;
    logic           vsync;
    logic           line_start;
    logic           frame_start;
    logic [FCW-1:0] frame_count;
  } tim_t;

  localparam tim_t TIM_RST = '{
    x:           '0,
    y:           '0,
    active:      1'b0,
    hsync:       ~HS_POL,
    vsync:       ~VS_POL,
    line_start:  1'b0,
    frame_start: 1'b0,
    frame_count: '0
  };

  logic [DW-1:0]  div_q, div_d;
  logic [CW-1:0]  hc_q, hc_d;
  logic [CW-1:0]  vc_q, vc_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic           fresh_q, fresh_d;
  logic           pix_ce;
  logic [CW:0]    hx, vx;
  tim_t           dec_d;
  tim_t           pipe_q [0:PIPE];

  assign pix_ce = tim.en && (div_q == DIV_LAST) && !rst;
  assign hx     = {1'b0, hc_q};
  assign vx     = {1'b0, vc_q};

  always_comb begin
    div_d = div_q;
    hc_d  = hc_q;
    vc_d  = vc_q;
    fc_d  = fc_q;
    if (tim.en) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end
    if (pix_ce) begin
      if (hc_q != H_LAST) begin
        hc_d = hc_q + 1'b1;
      end else begin
        hc_d = '0;
        if (vc_q != V_LAST) begin
          vc_d = vc_q + 1'b1;
        end else begin
          vc_d = '0;
          fc_d = fc_q + 1'b1;
        end
      end
    end
  end

  // fresh marks a counter position not yet shown on an enabled clk, so strobes fire once per pixel.
  always_comb begin
    fresh_d = fresh_q;
    if (pix_ce) begin
      fresh_d = 1'b1;
    end else if (tim.en) begin
      fresh_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      hc_q    <= '0;
      vc_q    <= '0;
      fc_q    <= '0;
      fresh_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      fc_q    <= fc_d;
      fresh_q <= fresh_d;
    end
  end

  always_comb begin
    dec_d             = pipe_q[0];
    dec_d.line_start  = 1'b0;
    dec_d.frame_start = 1'b0;
    if (tim.en) begin
      dec_d.x           = hc_q;
      dec_d.y           = vc_q;
      dec_d.active      = (hx < H_ACT_E) && (vx < V_ACT_E);
      dec_d.hsync       = ((hx >= H_SS_E) && (hx < H_SE_E)) ? HS_POL : ~HS_POL;
      dec_d.vsync       = ((vx >= V_SS_E) && (vx < V_SE_E)) ? VS_POL : ~VS_POL;
      dec_d.line_start  = fresh_q && (hc_q == '0);
      dec_d.frame_start = fresh_q && (hc_q == '0) && (vc_q == '0);
      dec_d.frame_count = fc_q;
    end
  end

  // Delay stages shift every clk regardless of en so the added latency is exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= PIPE; i++) begin
        pipe_q[i] <= TIM_RST;
      end
    end else begin
      pipe_q[0] <= dec_d;
      for (int i = 1; i <= PIPE; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tim.pix_ce      = pix_ce;
  assign tim.x           = pipe_q[PIPE].x;
  assign tim.y           = pipe_q[PIPE].y;
  assign tim.active      = pipe_q[PIPE].active;
  assign tim.hsync       = pipe_q[PIPE].hsync;
  assign tim.vsync       = pipe_q[PIPE].vsync;
  assign tim.line_start  = pipe_q[PIPE].line_start;
  assign tim.frame_start = pipe_q[PIPE].frame_start;
  assign tim.frame_count = pipe_q[PIPE].frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three generator configurations driven with random en/rst, checked against a pixel-index model.
module tb_vga_timing_gen;

  localparam int NCYC = 6000;

  typedef struct {
    int d, ha, hfp, hsw, hbp, va, vfp, vsw, vbp, fcw;
    bit hp, vp;
  } cfg_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic       act;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [2:0] fc;
  } ov_t;

  typedef struct {
    int  cyc;
    logic pa;
    logic pc;
    ov_t oa;
    ov_t ob;
    ov_t oc;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  int   checks = 0;
  int   errors = 0;
  rec_t q[$];

  always #5 clk = ~clk;

  vga_timing_gen_if #(.CW(4), .FCW(3)) ia();
  vga_timing_gen_if #(.CW(4), .FCW(3)) ib();
  vga_timing_gen_if #(.CW(4), .FCW(2)) ic();

  assign ia.en = en;
  assign ib.en = en;
  assign ic.en = en;

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .FCW(3), .PIPE(0)
  ) u_a (.clk(clk), .rst(rst), .tim(ia));

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(4), .FCW(3), .PIPE(3)
  ) u_b (.clk(clk), .rst(rst), .tim(ib));

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .FCW(2), .PIPE(0)
  ) u_c (.clk(clk), .rst(rst), .tim(ic));

  function automatic ov_t rst_out(cfg_t c);
    ov_t o;
    o     = '0;
    o.hs  = !c.hp;
    o.vs  = !c.vp;
    return o;
  endfunction

  // n = enabled clk edges since reset; the pixel shown is n / CLK_DIV in raster order.
  function automatic ov_t next_out(cfg_t c, int n, ov_t prev, logic e);
    ov_t o;
    int  ht, vt, p, x, y;
    if (!e) begin
      o    = prev;
      o.ls = 1'b0;
      o.fs = 1'b0;
      return o;
    end
    ht    = c.ha + c.hfp + c.hsw + c.hbp;
    vt    = c.va + c.vfp + c.vsw + c.vbp;
    p     = n / c.d;
    x     = p % ht;
    y     = (p / ht) % vt;
    o.x   = 4'(x);
    o.y   = 4'(y);
    o.act = (x < c.ha) && (y < c.va);
    o.hs  = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hsw) ? c.hp : !c.hp;
    o.vs  = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vsw) ? c.vp : !c.vp;
    o.ls  = ((n % c.d) == 0) && (x == 0);
    o.fs  = o.ls && (y == 0);
    o.fc  = 3'((p / (ht * vt)) % (1 << c.fcw));
    return o;
  endfunction

  function automatic ov_t pk(logic [3:0] x, logic [3:0] y, logic a, logic h, logic v,
                             logic l, logic f, logic [2:0] fc);
    ov_t o;
    o = {x, y, a, h, v, l, f, fc};
    return o;
  endfunction

  task automatic chk(string nm, int cyc, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      rec_t r;
      r = q.pop_front();
      chk("a_pix_ce", r.cyc, 32'(ia.pix_ce), 32'(r.pa));
      chk("a_out", r.cyc, 32'(pk(ia.x, ia.y, ia.active, ia.hsync, ia.vsync,
                                 ia.line_start, ia.frame_start, ia.frame_count)), 32'(r.oa));
      chk("b_pix_ce", r.cyc, 32'(ib.pix_ce), 32'(r.pa));
      chk("b_out", r.cyc, 32'(pk(ib.x, ib.y, ib.active, ib.hsync, ib.vsync,
                                 ib.line_start, ib.frame_start, ib.frame_count)), 32'(r.ob));
      chk("c_pix_ce", r.cyc, 32'(ic.pix_ce), 32'(r.pc));
      chk("c_out", r.cyc, 32'(pk(ic.x, ic.y, ic.active, ic.hsync, ic.vsync,
                                 ic.line_start, ic.frame_start, {1'b0, ic.frame_count})), 32'(r.oc));
    end
  end

  initial begin
    cfg_t ca, cc;
    ov_t  cur_a, cur_c;
    ov_t  hist[$];
    int   na, nc, r_last;
    logic r_j, e_j;
    rec_t rec;

    ca = '{d:2, ha:8, hfp:2, hsw:3, hbp:2, va:4, vfp:1, vsw:2, vbp:1, fcw:3, hp:1'b0, vp:1'b0};
    cc = '{d:1, ha:8, hfp:2, hsw:2, hbp:2, va:4, vfp:1, vsw:1, vbp:1, fcw:2, hp:1'b1, vp:1'b1};
    cur_a  = rst_out(ca);
    cur_c  = rst_out(cc);
    na     = 0;
    nc     = 0;
    r_last = 0;

    rst = 1'b1;
    en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int j = 0; j < NCYC; j++) begin
      r_j = 1'b0;
      if (j < 2) begin
        r_j = 1'b1;
        e_j = 1'b0;
      end else if (j == 2) begin
        e_j = 1'b1;
      end else if (j == 2503 || j == 4211) begin
        r_j = 1'b1;
        e_j = 1'b1;
      end else if (j == 5000) begin
        r_j = 1'b1;
        e_j = 1'b0;
      end else if (j >= 400 && j < 437) begin
        e_j = 1'b0;
      end else if (j >= 1000 && j < 3000) begin
        e_j = 1'b1;
      end else begin
        e_j = ($urandom_range(0, 9) != 0);
      end
      rst = r_j;
      en  = e_j;

      hist.push_back(cur_a);
      rec.cyc = j;
      rec.pa  = !r_j && e_j && ((na % ca.d) == ca.d - 1);
      rec.pc  = !r_j && e_j && ((nc % cc.d) == cc.d - 1);
      rec.oa  = cur_a;
      rec.ob  = (j - r_last < 3) ? rst_out(ca) : hist[j-3];
      rec.oc  = cur_c;
      q.push_back(rec);

      if (r_j) begin
        cur_a  = rst_out(ca);
        cur_c  = rst_out(cc);
        na     = 0;
        nc     = 0;
        r_last = j + 1;
      end else begin
        cur_a = next_out(ca, na, cur_a, e_j);
        cur_c = next_out(cc, nc, cur_c, e_j);
        if (e_j) begin
          na++;
          nc++;
        end
      end

      @(posedge clk);
      #1;
    end

    for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
